kamus_muldiv_seq: RTL and testbench

//  Iterative RV32M multiply/divide sequencer beside the EX stage. Latches operands on start,

---
 rtl/kamus_muldiv_seq_pkg.sv | 43 ++++
 rtl/kamus_muldiv_seq_step.sv | 39 +++
 rtl/kamus_muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_kamus_muldiv_seq.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/kamus_muldiv_seq_pkg.sv
// Shared types and constants for the RV32M multiply/divide sequencer.
package kamus_muldiv_seq_pkg;

  localparam int XLEN   = 32;
  // Counter wide enough for the radix-2 case (N_ITER-1 = 31).
  localparam int CNT_W  = 5;
  // Iterations at the default radix-2 setting.
  localparam int N_ITER = XLEN;

  typedef enum logic [2:0] {
    MD_MUL    = 3'd0,
    MD_MULH   = 3'd1,
    MD_MULHSU = 3'd2,
    MD_MULHU  = 3'd3,
    MD_DIV    = 3'd4,
    MD_DIVU   = 3'd5,
    MD_REM    = 3'd6,
    MD_REMU   = 3'd7
  } muldiv_op_e;

  // Sequencer states.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  // EX-stage operation list including the M-extension entries.
  typedef enum logic [4:0] {
    EX_ADD, EX_SUB, EX_AND, EX_OR, EX_XOR, EX_SLL, EX_SRL, EX_SRA,
    EX_SLT, EX_SLTU, EX_MUL, EX_MULH, EX_MULHSU, EX_MULHU,
    EX_DIV, EX_DIVU, EX_REM, EX_REMU
  } ex_op_e;

  // The top encoding bit separates divide/remainder from multiply.
  function automatic logic is_div_op(muldiv_op_e op);
    return op[2];
  endfunction

  // Number of iterations for a given number of bits retired per cycle.
  function automatic int n_iter(int ipc);
    return XLEN / ipc;
  endfunction

endpackage

// File: rtl/kamus_muldiv_seq_step.sv
// One combinational iteration: shift-add multiply step (LSB first) or
// restoring-divide step (MSB first) over a shared hi/lo register pair.
module kamus_muldiv_seq_step
  import kamus_muldiv_seq_pkg::*;
(
  input  logic        is_div_i,
  input  logic [31:0] hi_i,
  input  logic [31:0] lo_i,
  input  logic [31:0] opnd_i,
  output logic [31:0] hi_o,
  output logic [31:0] lo_o
);

  logic [32:0] sum;
  logic [32:0] rem_sh;
  logic [33:0] diff;

  // Multiply: add multiplicand when the current multiplier bit is set, then
  // shift the 65-bit {carry,hi,lo} right. Divide: shift in the next dividend
  // bit into the 33-bit partial remainder and subtract when it fits.
  always_comb begin
    sum    = {1'b0, hi_i} + {1'b0, (lo_i[0] ? opnd_i : 32'd0)};
    rem_sh = {hi_i, lo_i[31]};
    diff   = {1'b0, rem_sh} - {2'b00, opnd_i};
    if (is_div_i) begin
      if (!diff[33]) begin
        hi_o = diff[31:0];
        lo_o = {lo_i[30:0], 1'b1};
      end else begin
        hi_o = rem_sh[31:0];
        lo_o = {lo_i[30:0], 1'b0};
      end
    end else begin
      hi_o = sum[32:1];
      lo_o = {sum[0], lo_i[31:1]};
    end
  end

endmodule

// File: rtl/kamus_muldiv_seq.sv
// Iterative RV32M multiply/divide sequencer. Latches operand magnitudes on
// start, iterates ITER_PER_CYCLE steps per cycle, fixes signs, returns one result.
module kamus_muldiv_seq
  import kamus_muldiv_seq_pkg::*;
#(
  parameter int ITER_PER_CYCLE = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic [2:0]  op_i,
  input  logic [31:0] rs1_value_i,
  input  logic [31:0] rs2_value_i,
  input  logic        flush_i,
  output logic        stall_o,
  output logic        busy_o,
  output logic        valid_o,
  output logic [31:0] result_o
);

  localparam int              NI       = n_iter(ITER_PER_CYCLE);
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(NI - 1);

  logic [1:0]       state_q, state_d;
  muldiv_op_e       op_q, op_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      opnd_q, opnd_d;
  logic [31:0]      result_q, result_d;
  logic             negq_q, negq_d;
  logic             negr_q, negr_d;
  logic             valid_q, valid_d;

  muldiv_op_e  op_in;
  logic        in_div, a_neg, b_neg, div_by_zero, div_ovf;
  logic [31:0] a_abs, b_abs;
  logic        op_q_div;
  logic [31:0] hi_fin, lo_fin, final_res;
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_fix, rem_fix;

  assign op_in    = muldiv_op_e'(op_i);
  assign op_q_div = is_div_op(op_q);

  // Decode the incoming request: operand signedness, magnitudes, fast-path cases.
  always_comb begin
    in_div      = is_div_op(op_in);
    a_neg       = (op_in inside {MD_MUL, MD_MULH, MD_MULHSU, MD_DIV, MD_REM}) && rs1_value_i[31];
    b_neg       = (op_in inside {MD_MUL, MD_MULH, MD_DIV, MD_REM}) && rs2_value_i[31];
    a_abs       = a_neg ? (~rs1_value_i + 32'd1) : rs1_value_i;
    b_abs       = b_neg ? (~rs2_value_i + 32'd1) : rs2_value_i;
    div_by_zero = (rs2_value_i == 32'd0);
    div_ovf     = (op_in inside {MD_DIV, MD_REM}) &&
                  (rs1_value_i == 32'h8000_0000) && (rs2_value_i == 32'hFFFF_FFFF);
  end

  // Chain of single-bit steps; each stage feeds the next within one cycle.
  for (genvar g = 0; g < ITER_PER_CYCLE; g++) begin : g_step
    logic [31:0] hi_in, lo_in, hi_out, lo_out;
    if (g == 0) begin : g_first
      assign hi_in = hi_q;
      assign lo_in = lo_q;
    end else begin : g_next
      assign hi_in = g_step[g-1].hi_out;
      assign lo_in = g_step[g-1].lo_out;
    end
    kamus_muldiv_seq_step u_step (
      .is_div_i (op_q_div),
      .hi_i     (hi_in),
      .lo_i     (lo_in),
      .opnd_i   (opnd_q),
      .hi_o     (hi_out),
      .lo_o     (lo_out)
    );
  end

  assign hi_fin = g_step[ITER_PER_CYCLE-1].hi_out;
  assign lo_fin = g_step[ITER_PER_CYCLE-1].lo_out;

  // Sign correction of the finished magnitude result and selection of the returned word.
  always_comb begin
    prod     = {hi_fin, lo_fin};
    prod_fix = negq_q ? (~prod + 64'd1) : prod;
    quot_fix = negq_q ? (~lo_fin + 32'd1) : lo_fin;
    rem_fix  = negr_q ? (~hi_fin + 32'd1) : hi_fin;
    case (op_q)
      MD_MUL:                       final_res = prod_fix[31:0];
      MD_MULH, MD_MULHSU, MD_MULHU: final_res = prod_fix[63:32];
      MD_DIV, MD_DIVU:              final_res = quot_fix;
      MD_REM, MD_REMU:              final_res = rem_fix;
      default:                      final_res = prod_fix[31:0];
    endcase
  end

  // Sequencer next-state: accept/fast-path in IDLE, iterate in CALC, one-cycle DONE.
  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    opnd_d   = opnd_q;
    negq_d   = negq_q;
    negr_d   = negr_q;
    result_d = result_q;
    valid_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start_i && !flush_i) begin
          op_d = op_in;
          if (in_div && div_by_zero) begin
            result_d = (op_in inside {MD_DIV, MD_DIVU}) ? 32'hFFFF_FFFF : rs1_value_i;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else if (div_ovf) begin
            result_d = (op_in == MD_DIV) ? 32'h8000_0000 : 32'd0;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            // Multiply: opnd holds multiplicand, lo the multiplier.
            // Divide: opnd holds divisor, lo the dividend (becomes quotient).
            hi_d    = 32'd0;
            opnd_d  = in_div ? b_abs : a_abs;
            lo_d    = in_div ? a_abs : b_abs;
            negq_d  = a_neg ^ b_neg;
            negr_d  = a_neg;
            cnt_d   = CNT_INIT;
            state_d = ST_CALC;
          end
        end
      end
      ST_CALC: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          hi_d = hi_fin;
          lo_d = lo_fin;
          if (cnt_q == '0) begin
            result_d = final_res;
            valid_d  = 1'b1;
            state_d  = ST_DONE;
          end else begin
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // State and datapath registers, cleared by the asynchronous reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_IDLE;
      op_q     <= MD_MUL;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      opnd_q   <= '0;
      negq_q   <= 1'b0;
      negr_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      opnd_q   <= opnd_d;
      negq_q   <= negq_d;
      negr_q   <= negr_d;
      result_q <= result_d;
      valid_q  <= valid_d;
    end
  end

  assign busy_o   = (state_q != ST_IDLE);
  assign valid_o  = valid_q;
  assign result_o = result_q;
  assign stall_o  = ((state_q == ST_IDLE) && start_i && !flush_i) || (state_q == ST_CALC);

endmodule

// File: tb/tb_kamus_muldiv_seq.sv
// Bench for kamus_muldiv_seq: three instances (1, 2 and 4 bits per cycle)
// share one stimulus stream; a scoreboard queue holds the expected results.
module tb_kamus_muldiv_seq;
  import kamus_muldiv_seq_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, flush_i;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic [2:0]  busy_w, stall_w, valid_w;
  logic [31:0] res_w [3];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [31:0] exp_q [$];
  int          iss_q [$];
  bit          fast_q[$];
  int          rd_ptr   [3];
  int          stall_cnt[3];

  always #5 clk = ~clk;

  kamus_muldiv_seq #(.ITER_PER_CYCLE(1)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .op_i(op),
    .rs1_value_i(a), .rs2_value_i(b), .flush_i(flush_i),
    .stall_o(stall_w[0]), .busy_o(busy_w[0]), .valid_o(valid_w[0]), .result_o(res_w[0]));

  kamus_muldiv_seq #(.ITER_PER_CYCLE(2)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .op_i(op),
    .rs1_value_i(a), .rs2_value_i(b), .flush_i(flush_i),
    .stall_o(stall_w[1]), .busy_o(busy_w[1]), .valid_o(valid_w[1]), .result_o(res_w[1]));

  kamus_muldiv_seq #(.ITER_PER_CYCLE(4)) u_dut4 (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start_i), .op_i(op),
    .rs1_value_i(a), .rs2_value_i(b), .flush_i(flush_i),
    .stall_o(stall_w[2]), .busy_o(busy_w[2]), .valid_o(valid_w[2]), .result_o(res_w[2]));

  function automatic int nit(int k);
    case (k)
      0:       return 32;
      1:       return 16;
      default: return 8;
    endcase
  endfunction

  // Reference model built on native 64-bit / signed arithmetic.
  function automatic logic [31:0] ref_md(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    logic signed [31:0] sx, sy, sq;
    logic signed [63:0] lx, ly, lp;
    logic [63:0]        p;
    sx = x; sy = y;
    case (muldiv_op_e'(o))
      MD_MUL:    begin p = {32'd0, x} * {32'd0, y}; return p[31:0]; end
      MD_MULH:   begin lx = sx; ly = sy; lp = lx * ly; return lp[63:32]; end
      MD_MULHSU: begin p = {{32{x[31]}}, x} * {32'd0, y}; return p[63:32]; end
      MD_MULHU:  begin p = {32'd0, x} * {32'd0, y}; return p[63:32]; end
      MD_DIV: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        sq = sx / sy; return sq;
      end
      MD_DIVU: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      MD_REM: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'd0;
        sq = sx % sy; return sq;
      end
      default: return (y == 0) ? x : x % y;
    endcase
  endfunction

  function automatic bit fast_of(logic [2:0] o, logic [31:0] x, logic [31:0] y);
    return o[2] && ((y == 0) ||
           ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 && y == 32'hFFFF_FFFF));
  endfunction

  function automatic bit all_done();
    for (int k = 0; k < 3; k++) if (rd_ptr[k] != exp_q.size()) return 1'b0;
    return 1'b1;
  endfunction

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // One clock: sample outputs at the falling edge, then move past the rising edge.
  task automatic tick();
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      if (!busy_w[k]) stall_cnt[k] = 0;
      else if (stall_w[k]) stall_cnt[k]++;
      if (valid_w[k]) begin
        if (rd_ptr[k] < exp_q.size()) begin
          int r;
          int lat;
          r   = rd_ptr[k];
          lat = fast_q[r] ? 1 : nit(k) + 1;
          chk32($sformatf("result d%0d n%0d", k, r), res_w[k], exp_q[r]);
          chk32($sformatf("latency d%0d n%0d", k, r), 32'(cyc - iss_q[r]), 32'(lat));
          chk32($sformatf("stall_cycles d%0d n%0d", k, r), 32'(stall_cnt[k]),
                fast_q[r] ? 32'd0 : 32'(nit(k)));
          rd_ptr[k]++;
        end else begin
          chk32($sformatf("unexpected_valid d%0d", k), {31'd0, valid_w[k]}, 32'd0);
        end
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 60 && !all_done(); i++) tick();
    total++;
    assert (all_done()) else begin
      bad++;
      $error("FAIL timeout observed=%0d/%0d/%0d expected=%0d", rd_ptr[0], rd_ptr[1], rd_ptr[2], exp_q.size());
    end
    for (int k = 0; k < 3; k++) chk32($sformatf("result_hold d%0d", k), res_w[k], exp_q[$]);
  endtask

  // Issue one op (start held hold+1 cycles), scramble inputs, wait for all results.
  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y,
                        input logic [31:0] expv, input int hold);
    op = o; a = x; b = y; start_i = 1'b1;
    exp_q.push_back(expv);
    iss_q.push_back(cyc);
    fast_q.push_back(fast_of(o, x, y));
    for (int i = 0; i <= hold; i++) tick();
    start_i = 1'b0;
    op = 3'($urandom_range(0, 7)); a = $urandom; b = $urandom;
    wait_done();
  endtask

  initial begin
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    rst_n = 1'b0; start_i = 1'b0; flush_i = 1'b0; op = 3'd0; a = '0; b = '0;
    for (int k = 0; k < 3; k++) begin rd_ptr[k] = 0; stall_cnt[k] = 0; end
    repeat (2) @(posedge clk);
    #1;
    chk32("reset_busy",  {29'd0, busy_w},  32'd0);
    chk32("reset_valid", {29'd0, valid_w}, 32'd0);
    chk32("reset_stall", {29'd0, stall_w}, 32'd0);
    for (int k = 0; k < 3; k++) chk32($sformatf("reset_result d%0d", k), res_w[k], 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Directed multiply / divide set, including fast-path cases.
    run_op(MD_MUL,    32'd7,           32'hFFFF_FFFD, 32'hFFFF_FFEB, 0);
    run_op(MD_MULH,   32'h8000_0000,   32'h8000_0000, 32'h4000_0000, 0);
    run_op(MD_MULHU,  32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFE, 0);
    run_op(MD_MULHSU, 32'hFFFF_FFFF,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(MD_DIV,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFD, 0);
    run_op(MD_REM,    32'hFFFF_FFF9,   32'd2,         32'hFFFF_FFFF, 0);
    run_op(MD_DIVU,   32'd100,         32'd7,         32'd14,        0);
    run_op(MD_REMU,   32'd100,         32'd7,         32'd2,         0);
    run_op(MD_DIVU,   32'd5,           32'd0,         32'hFFFF_FFFF, 0);
    run_op(MD_REM,    32'd5,           32'd0,         32'd5,         0);
    run_op(MD_DIV,    32'h8000_0000,   32'hFFFF_FFFF, 32'h8000_0000, 0);
    run_op(MD_REM,    32'h8000_0000,   32'hFFFF_FFFF, 32'd0,         0);

    // Random operands against the reference model.
    for (int i = 0; i < 12; i++) begin
      ro = 3'(i % 8);
      ra = $urandom;
      rb = (i % 3 == 0) ? 32'($urandom_range(1, 100)) : $urandom;
      if (i % 4 == 1) rb = -rb;
      run_op(ro, ra, rb, ref_md(ro, ra, rb), 0);
    end

    // start_i held through busy and the fastest instance's DONE cycle.
    run_op(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0, ref_md(MD_MULHU, 32'h1234_5678, 32'h9ABC_DEF0), 9);

    // Flush mid-CALC: no result, back to idle, new start accepted at once.
    op = MD_DIVU; a = 32'd100; b = 32'd7; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (4) tick();
    flush_i = 1'b1;
    tick();
    flush_i = 1'b0;
    chk32("flush_busy",  {29'd0, busy_w},  32'd0);
    chk32("flush_stall", {29'd0, stall_w}, 32'd0);
    chk32("flush_valid", {29'd0, valid_w}, 32'd0);
    run_op(MD_DIVU, 32'd1000, 32'd9, 32'd111, 0);

    // Flush and start together in IDLE: flush wins.
    op = MD_MUL; a = 32'd3; b = 32'd5; start_i = 1'b1; flush_i = 1'b1;
    #1;
    chk32("flush_start_stall", {29'd0, stall_w}, 32'd0);
    tick();
    start_i = 1'b0; flush_i = 1'b0;
    chk32("flush_start_busy", {29'd0, busy_w}, 32'd0);

    // Asynchronous reset in the middle of CALC.
    op = MD_MUL; a = 32'd9; b = 32'd9; start_i = 1'b1;
    tick();
    start_i = 1'b0;
    repeat (3) tick();
    rst_n = 1'b0;
    #1;
    chk32("rst_mid_busy",  {29'd0, busy_w},  32'd0);
    chk32("rst_mid_valid", {29'd0, valid_w}, 32'd0);
    for (int k = 0; k < 3; k++) chk32($sformatf("rst_mid_result d%0d", k), res_w[k], 32'd0);
    tick();
    rst_n = 1'b1;
    run_op(MD_REM, 32'hFFFF_FF9C, 32'd7, 32'hFFFF_FFFE, 0);

    // Idle tail: any late or duplicated valid_o is flagged by tick().
    repeat (40) tick();
    for (int k = 0; k < 3; k++) chk32($sformatf("final_count d%0d", k), 32'(rd_ptr[k]), 32'(exp_q.size()));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
